// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel and
// the valid/ready instruction channel towards decode.
// master = fetch stage, slave = environment (instruction memory + decode).
interface instr_fetch_if #(
   parameter int ADDR_W = 32
);
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_resp_valid;
   logic [31:0]       imem_resp_data;
   logic              inst_valid;
   logic              inst_ready;
   logic [31:0]       inst_data;
   logic [ADDR_W-1:0] inst_pc;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      output inst_valid, inst_data, inst_pc,
      input  inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      input  inst_valid, inst_data, inst_pc,
      output inst_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Issues the current PC as a word-address request
// whenever a buffer entry is free, keeps a DEPTH-entry in-order buffer of
// issued requests, fills entries with in-order memory responses and hands
// them to decode over valid/ready. A flush empties the buffer and turns all
// still-outstanding responses into drops (DRAIN state until they return).
// Optional macro IFETCH_PERF_EN adds saturating perf_fetched / perf_stall
// counters as extra output ports.
module instr_fetch #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_in,
   output logic              pc_enable,
   input  logic              flush,
   instr_fetch_if.master     bus
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_stall
`endif
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int DROP_W = $clog2(2 * DEPTH) + 1;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   // Buffer entries: pc, data, filled
   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [31:0]       data_mem [DEPTH];
   logic [DEPTH-1:0]  filled;

   logic [PTR_W-1:0]  alloc_ptr, fill_ptr, head_ptr;
   logic [CNT_W-1:0]  alloc_cnt;   // issued but not yet popped
   logic [CNT_W-1:0]  pend_cnt;    // issued, response still owed (live)
   logic [DROP_W-1:0] drop_cnt, drop_nxt;
   logic [0:0]        state, state_nxt;

   logic issue, fill, drop, pop;

   // Issue side: a free entry is the credit for one request
   assign bus.imem_req_valid = rst && (alloc_cnt < CNT_W'(DEPTH)) && !flush;
   assign bus.imem_req_addr  = pc_in;
   assign pc_enable          = bus.imem_req_valid && bus.imem_req_ready;
   assign issue              = pc_enable;

   // Decode side: head entry viewed straight from the registers
   assign bus.inst_valid = filled[head_ptr];
   assign bus.inst_data  = data_mem[head_ptr];
   assign bus.inst_pc    = pc_mem[head_ptr];
   assign pop            = bus.inst_valid && bus.inst_ready && !flush;

   // Responses owed to flushed requests are discarded first; a response with
   // nothing outstanding is a protocol error and falls through both terms.
   assign drop = bus.imem_resp_valid && (state == ST_DRAIN);
   assign fill = bus.imem_resp_valid && (state == ST_RUN) && (pend_cnt != '0);

   // Next drop count: a flush converts all live outstanding requests to drops
   always_comb begin
      // NOTE: default assignment first so no path leaves drop_nxt unassigned (no latch).
      drop_nxt = drop_cnt;
      if (flush) begin
         drop_nxt = drop_cnt + DROP_W'(pend_cnt) - DROP_W'(drop || fill);
      end else if (drop) begin
         drop_nxt = drop_cnt - DROP_W'(1);
      end
   end

   // RUN/DRAIN: DRAIN exactly while stale responses are still owed
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   if (flush && (drop_nxt != '0)) state_nxt = ST_DRAIN;
         ST_DRAIN: if (drop_nxt == '0)            state_nxt = ST_RUN;
      endcase
   end

   // Buffer, pointers, counters and FSM state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         alloc_cnt <= '0;
         pend_cnt  <= '0;
         drop_cnt  <= '0;
         filled    <= '0;
         state     <= ST_RUN;
         // NOTE: the buffer arrays are reset because inst_data/inst_pc read them directly and must be 0 out of reset.
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            data_mem[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments so every update below sees pre-edge values.
         drop_cnt <= drop_nxt;
         state    <= state_nxt;
         if (flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            alloc_cnt <= '0;
            pend_cnt  <= '0;
            filled    <= '0;
         end else begin
            // issue, fill and pop always touch distinct entries
            if (issue) begin
               pc_mem[alloc_ptr] <= pc_in;
               filled[alloc_ptr] <= 1'b0;
               alloc_ptr         <= alloc_ptr + PTR_W'(1);
            end
            if (fill) begin
               data_mem[fill_ptr] <= bus.imem_resp_data;
               filled[fill_ptr]   <= 1'b1;
               fill_ptr           <= fill_ptr + PTR_W'(1);
            end
            if (pop) begin
               filled[head_ptr] <= 1'b0;
               head_ptr         <= head_ptr + PTR_W'(1);
            end
            alloc_cnt <= alloc_cnt + CNT_W'(issue) - CNT_W'(pop);
            pend_cnt  <= pend_cnt + CNT_W'(issue) - CNT_W'(fill);
         end
      end
   end

`ifdef IFETCH_PERF_EN
   // Saturating counters: instructions handed to decode, decode starve cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (pop && (perf_fetched != '1)) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         if (!bus.inst_valid && bus.inst_ready && (perf_stall != '1)) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// traffic, checked every cycle against a queue-based reference model
// (live requests, returned instructions, count of responses to drop) and an
// in-order instruction-memory model with per-request latency.
module tb_instr_fetch;

   localparam int ADDR_W = 32;
   localparam int DEPTH  = 4;

   logic              clk;
   logic              rst;
   logic [ADDR_W-1:0] pc_in;
   logic              pc_enable;
   logic              flush;
`ifdef IFETCH_PERF_EN
   logic [31:0]       perf_fetched;
   logic [31:0]       perf_stall;
`endif

   instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

   instr_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .pc_in     (pc_in),
      .pc_enable (pc_enable),
      .flush     (flush),
      .bus       (bus)
`ifdef IFETCH_PERF_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model state ----------------
   typedef struct {
      logic [ADDR_W-1:0] addr;
      int                due;
   } mreq_t;

   typedef struct {
      logic [ADDR_W-1:0] pc;
      logic [31:0]       data;
   } inst_t;

   mreq_t             mem_q[$];   // requests the memory still has to answer
   logic [ADDR_W-1:0] pend_q[$];  // live requests awaiting their response
   inst_t             rdy_q[$];   // returned instructions awaiting decode
   int                stale;      // responses that must be thrown away
   int                cyc;
   int                last_due;
   logic [ADDR_W-1:0] pc_reg;     // program counter driving pc_in
   int                m_fetched;
   int                m_stall;

   logic [ADDR_W-1:0] seen_q[$];  // pcs observed leaving the DUT
   int                pe_cnt;
   int                t_issue;
   int                t_iv;

   int n_cmp;
   int n_bad;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_data(input logic [ADDR_W-1:0] a);
      return {a[23:0], 8'h13};
   endfunction

   // One clock cycle: drive at negedge, check at negedge+1, advance model.
   task automatic step(input bit fl, input logic [ADDR_W-1:0] tgt, input bit rq_rdy,
                       input bit i_rdy, input int lat);
      bit                exp_req, exp_iv, issue, pop, resp, fl_eff;
      logic [31:0]       rdata;
      logic [ADDR_W-1:0] p;
      int                d;
      @(negedge clk);
      fl_eff              = fl && rst;
      flush               = fl_eff;
      pc_in               = pc_reg;
      bus.imem_req_ready  = rq_rdy;
      bus.inst_ready      = i_rdy;
      resp                = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      rdata               = resp ? mem_data(mem_q[0].addr) : 32'($urandom);
      bus.imem_resp_valid = resp;
      bus.imem_resp_data  = rdata;
      #1;
      exp_req = rst && !fl_eff && ((pend_q.size() + rdy_q.size()) < DEPTH);
      exp_iv  = rst && (rdy_q.size() > 0);
      check("req_valid", bus.imem_req_valid, exp_req);
      check("pc_enable", pc_enable, exp_req && rq_rdy);
      if (exp_req) check("req_addr", bus.imem_req_addr, pc_reg);
      check("inst_valid", bus.inst_valid, exp_iv);
      if (exp_iv) begin
         check("inst_pc", bus.inst_pc, rdy_q[0].pc);
         check("inst_data", bus.inst_data, rdy_q[0].data);
      end
      if (!rst) begin
         check("rst_inst_pc", bus.inst_pc, '0);
         check("rst_inst_data", bus.inst_data, '0);
      end
`ifdef IFETCH_PERF_EN
      check("perf_fetched", perf_fetched, 32'(m_fetched));
      check("perf_stall", perf_stall, 32'(m_stall));
`endif
      // observations used by the directed scenarios
      if (pc_enable) pe_cnt++;
      if (bus.inst_valid && i_rdy && !fl_eff && rst) seen_q.push_back(bus.inst_pc);
      if (bus.inst_valid && t_iv < 0) t_iv = cyc;

      // model update for the coming rising edge
      issue = exp_req && rq_rdy;
      pop   = exp_iv && i_rdy && !fl_eff;
      if (issue && t_issue < 0) t_issue = cyc;
      if (resp) void'(mem_q.pop_front());
      if (rst) begin
         if (!exp_iv && i_rdy) m_stall++;
         if (pop) begin
            void'(rdy_q.pop_front());
            m_fetched++;
         end
         if (resp) begin
            if (stale > 0) begin
               stale--;
            end else if (pend_q.size() > 0) begin
               p = pend_q.pop_front();
               rdy_q.push_back('{pc: p, data: rdata});
            end
         end
         if (fl_eff) begin
            stale += pend_q.size();
            pend_q.delete();
            rdy_q.delete();
            pc_reg = tgt;
         end else if (issue) begin
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend_q.push_back(pc_reg);
            mem_q.push_back('{addr: pc_reg, due: d});
            pc_reg = pc_reg + 1;
         end
      end
      cyc++;
   endtask

   // Let everything in flight drain out with no new requests.
   task automatic drain();
      int n;
      n = 0;
      while (((pend_q.size() + rdy_q.size() + mem_q.size()) > 0 || bus.inst_valid) && n < 60) begin
         step(1'b0, '0, 1'b0, 1'b1, 1);
         n++;
      end
      check("drain_empty", bus.inst_valid, 1'b0);
   endtask

   // Fetch with memory ready until the first instruction reaches decode.
   task automatic wait_first(input string tag, input logic [ADDR_W-1:0] exp);
      int n;
      n = 0;
      while (seen_q.size() == 0 && n < 30) begin
         step(1'b0, '0, 1'b1, 1'b1, 1);
         n++;
      end
      check(tag, (seen_q.size() > 0) ? 64'(seen_q[0]) : 64'hDEAD_0000_DEAD, 64'(exp));
   endtask

   // Assert reset mid-cycle (after a no-issue step), hold, release mid-cycle.
   task automatic async_reset(input int hold);
      #1;
      rst = 1'b0;
      #1;
      check("arst_req_valid", bus.imem_req_valid, 1'b0);
      check("arst_pc_enable", pc_enable, 1'b0);
      check("arst_inst_valid", bus.inst_valid, 1'b0);
      check("arst_inst_data", bus.inst_data, '0);
      check("arst_inst_pc", bus.inst_pc, '0);
`ifdef IFETCH_PERF_EN
      check("arst_perf_fetched", perf_fetched, '0);
      check("arst_perf_stall", perf_stall, '0);
`endif
      pend_q.delete();
      rdy_q.delete();
      stale     = 0;
      m_fetched = 0;
      m_stall   = 0;
      repeat (hold) step(1'b0, '0, 1'b0, 1'b0, 1);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; cyc = 0; last_due = -1; stale = 0;
      m_fetched = 0; m_stall = 0; pe_cnt = 0; t_issue = -1; t_iv = -1;
      pc_reg = '0;
      flush = 1'b0; pc_in = '0;
      bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data = '0;   bus.inst_ready = 1'b0;
      rst = 1'b1;
      #1 rst = 1'b0;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      #1;
      check("reset_req_valid", bus.imem_req_valid, 1'b0);
      check("reset_pc_enable", pc_enable, 1'b0);
      check("reset_inst_valid", bus.inst_valid, 1'b0);
      check("reset_inst_data", bus.inst_data, '0);
      check("reset_inst_pc", bus.inst_pc, '0);
      rst = 1'b1;

      // ---- streaming: 1-cycle memory, decode always ready ----
      seen_q.delete(); pe_cnt = 0; t_issue = -1; t_iv = -1;
      repeat (8) step(1'b0, '0, 1'b1, 1'b1, 1);
      check("stream_pe_every_cycle", pe_cnt, 8);
      check("stream_first_latency", t_iv - t_issue, 2);
      for (int i = 0; i < 4; i++)
         check("stream_pc_seq", (seen_q.size() > i) ? 64'(seen_q[i]) : 64'hDEAD, 64'(i));
      drain();

      // ---- decode stalled: exactly DEPTH requests, then in-order pops ----
      pc_reg = '0; seen_q.delete(); pe_cnt = 0;
      repeat (8) step(1'b0, '0, 1'b1, 1'b0, 1);
      check("full_issue_count", pe_cnt, DEPTH);
      repeat (6) step(1'b0, '0, 1'b0, 1'b1, 1);
      for (int i = 0; i < DEPTH; i++)
         check("full_pop_order", (seen_q.size() > i) ? 64'(seen_q[i]) : 64'hDEAD, 64'(i));
      drain();

      // ---- flush with 3 outstanding requests on a slow memory ----
      pc_reg = 32'h20;
      repeat (3) step(1'b0, '0, 1'b1, 1'b1, 4);
      step(1'b1, 32'h40, 1'b1, 1'b1, 1);
      seen_q.delete();
      wait_first("flush_first_pc", 32'h40);
      drain();

      // ---- flush coinciding with a response and a pop, 2 outstanding ----
      pc_reg = 32'h60;
      step(1'b0, '0, 1'b1, 1'b0, 1);
      step(1'b0, '0, 1'b1, 1'b0, 2);
      step(1'b0, '0, 1'b1, 1'b0, 2);
      check("coinc_head_ready", bus.inst_valid, 1'b1);
      step(1'b1, 32'h80, 1'b1, 1'b1, 1);
      check("coinc_drop_one", stale, 1);
      seen_q.delete();
      step(1'b0, '0, 1'b1, 1'b1, 1);
      wait_first("coinc_first_pc", 32'h80);
      drain();

      // ---- asynchronous reset with 2 outstanding ----
      pc_reg = 32'h200;
      repeat (2) step(1'b0, '0, 1'b1, 1'b1, 4);
      step(1'b0, '0, 1'b0, 1'b1, 4);
      async_reset(2);
      pc_reg = 32'h100;
      for (int n = 0; n < 20 && mem_q.size() > 0; n++) step(1'b0, '0, 1'b0, 1'b1, 1);
      seen_q.delete();
      wait_first("rst_restart_pc", 32'h100);
      drain();

`ifdef IFETCH_PERF_EN
      // ---- performance counters ----
      step(1'b0, '0, 1'b0, 1'b0, 1);
      async_reset(1);
      repeat (5) step(1'b0, '0, 1'b0, 1'b1, 1);
      @(posedge clk); #1;
      check("perf_stall_5", perf_stall, 32'd5);
      repeat (10) step(1'b0, '0, 1'b1, 1'b1, 1);
      drain();
      @(posedge clk); #1;
      check("perf_fetched_10", perf_fetched, 32'd10);
      step(1'b0, '0, 1'b0, 1'b0, 1);
      async_reset(1);
`endif

      // ---- random traffic ----
      for (int i = 0; i < 1500; i++) begin
         step(($urandom % 20) == 0, 32'($urandom), ($urandom % 4) != 0,
              ($urandom % 10) < 7, 1 + int'($urandom % 5));
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
